// File: rtl/mmx_pkg.sv
// rtl/mmx_pkg.sv - shared MMX register-file constants and types
package mmx_pkg;

  localparam int MMX_DATA_W = 64;
  localparam int MMX_SEL_W  = 3;
  localparam int MMX_NREGS  = 8;

  typedef logic [MMX_SEL_W-1:0]  mmx_sel_t;
  typedef logic [MMX_DATA_W-1:0] mmx_data_t;

  // One-hot register vector for a select, all zero when not enabled.
  function automatic logic [MMX_NREGS-1:0] mmx_onehot(input mmx_sel_t sel, input logic en);
    logic [MMX_NREGS-1:0] vec;
    vec = '0;
    if (en) vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/mmx_operand_mux.sv
// rtl/mmx_operand_mux.sv - 8:1 operand select with writeback bypass override
module mmx_operand_mux
  import mmx_pkg::*;
#(
  parameter int DATA_WIDTH = MMX_DATA_W
) (
  input  logic [DATA_WIDTH-1:0] regs [MMX_NREGS],
  input  mmx_sel_t              sel,
  input  logic [DATA_WIDTH-1:0] wb_data,
  input  logic                  bypass,
  output logic [DATA_WIDTH-1:0] data
);

  // Bypass is only asserted when the writeback targets sel this cycle.
  always_comb begin
    data = regs[sel];
    if (bypass) data = wb_data;
  end

endmodule

// File: rtl/mmx_operand_read.sv
// rtl/mmx_operand_read.sv - MMX operand read, pending scoreboard and 1-deep issue stage (option: MMX_WB_BYPASS_EN)
module mmx_operand_read
  import mmx_pkg::*;
#(
  parameter int DATA_WIDTH = MMX_DATA_W,
  parameter int SEL_WIDTH  = MMX_SEL_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_WIDTH-1:0]  src_a_sel,
  input  logic [SEL_WIDTH-1:0]  src_b_sel,
  input  logic [SEL_WIDTH-1:0]  dst_sel,
  input  logic                  dst_en,
  input  logic [DATA_WIDTH-1:0] mm0_in,
  input  logic [DATA_WIDTH-1:0] mm1_in,
  input  logic [DATA_WIDTH-1:0] mm2_in,
  input  logic [DATA_WIDTH-1:0] mm3_in,
  input  logic [DATA_WIDTH-1:0] mm4_in,
  input  logic [DATA_WIDTH-1:0] mm5_in,
  input  logic [DATA_WIDTH-1:0] mm6_in,
  input  logic [DATA_WIDTH-1:0] mm7_in,
  input  logic [DATA_WIDTH-1:0] writeback_data,
  input  logic [SEL_WIDTH-1:0]  writeback_select,
  input  logic                  writeback_enable,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [SEL_WIDTH-1:0]  out_dst_sel,
  output logic                  out_dst_en
);

  logic [DATA_WIDTH-1:0] mm [MMX_NREGS];
  logic [MMX_NREGS-1:0]  wb_hit;
  logic [MMX_NREGS-1:0]  bypass_ok;
  logic [MMX_NREGS-1:0]  pending;
  logic [MMX_NREGS-1:0]  set_vec;
  logic [DATA_WIDTH-1:0] data_a;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  hazard_a;
  logic                  hazard_b;
  logic                  hazard_waw;
  logic                  stall;
  logic                  accept;

  assign mm[0] = mm0_in;
  assign mm[1] = mm1_in;
  assign mm[2] = mm2_in;
  assign mm[3] = mm3_in;
  assign mm[4] = mm4_in;
  assign mm[5] = mm5_in;
  assign mm[6] = mm6_in;
  assign mm[7] = mm7_in;

  assign wb_hit = mmx_onehot(writeback_select, writeback_enable);

`ifdef MMX_WB_BYPASS_EN
  // A register being written back is readable in the same cycle.
  assign bypass_ok = wb_hit;
`else
  // Without bypass a pending source waits until the cycle after its writeback.
  assign bypass_ok = '0;
`endif

  // Hazard detection and handshake; in_ready does not look at in_valid.
  always_comb begin
    hazard_a   = pending[src_a_sel] & ~bypass_ok[src_a_sel];
    hazard_b   = pending[src_b_sel] & ~bypass_ok[src_b_sel];
    hazard_waw = dst_en & pending[dst_sel] & ~wb_hit[dst_sel];
    stall      = hazard_a | hazard_b | hazard_waw;
    in_ready   = (~out_valid | out_ready) & ~stall;
    accept     = in_valid & in_ready;
    set_vec    = mmx_onehot(dst_sel, accept & dst_en);
  end

  mmx_operand_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux_a (
    .regs    (mm),
    .sel     (src_a_sel),
    .wb_data (writeback_data),
    .bypass  (bypass_ok[src_a_sel]),
    .data    (data_a)
  );

  mmx_operand_mux #(.DATA_WIDTH(DATA_WIDTH)) u_mux_b (
    .regs    (mm),
    .sel     (src_b_sel),
    .wb_data (writeback_data),
    .bypass  (bypass_ok[src_b_sel]),
    .data    (data_b)
  );

  // Scoreboard: a new destination claim beats a writeback clear on the same register.
  always_ff @(posedge clk) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~wb_hit) | set_vec;
  end

  // Issue stage: load on accept, drain when execute takes the op, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      op_a        <= '0;
      op_b        <= '0;
      out_dst_sel <= '0;
      out_dst_en  <= 1'b0;
    end else if (accept) begin
      out_valid   <= 1'b1;
      op_a        <= data_a;
      op_b        <= data_b;
      out_dst_sel <= dst_sel;
      out_dst_en  <= dst_en;
    end else if (out_ready) begin
      out_valid   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mmx_operand_read.sv
// tb/tb_mmx_operand_read.sv - self-checking bench for mmx_operand_read (either MMX_WB_BYPASS_EN build)
module tb_mmx_operand_read;

`ifdef MMX_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, iv, de, we, ordy;
  logic [2:0]  sa, sb, ds, ws;
  logic [63:0] wbd;
  logic [63:0] mm [8];
  logic        in_ready, out_valid, out_dst_en;
  logic [63:0] op_a, op_b;
  logic [2:0]  out_dst_sel;

  int total = 0;
  int bad   = 0;

  bit        m_valid;
  bit [63:0] m_a, m_b;
  bit [2:0]  m_dsel;
  bit        m_den;
  bit        m_pend [8];
  logic      seen_rdy;

  always #5 clk = ~clk;

  mmx_operand_read dut (
    .clk(clk), .reset(rst), .in_valid(iv), .in_ready(in_ready),
    .src_a_sel(sa), .src_b_sel(sb), .dst_sel(ds), .dst_en(de),
    .mm0_in(mm[0]), .mm1_in(mm[1]), .mm2_in(mm[2]), .mm3_in(mm[3]),
    .mm4_in(mm[4]), .mm5_in(mm[5]), .mm6_in(mm[6]), .mm7_in(mm[7]),
    .writeback_data(wbd), .writeback_select(ws), .writeback_enable(we),
    .out_valid(out_valid), .out_ready(ordy), .op_a(op_a), .op_b(op_b),
    .out_dst_sel(out_dst_sel), .out_dst_en(out_dst_en)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic bit hit(int r);
    return we && (int'(ws) == r);
  endfunction

  function automatic bit src_free(int s);
    return !m_pend[s] || (BYP && hit(s));
  endfunction

  function automatic bit model_ready();
    bit waw;
    waw = de && m_pend[ds] && !hit(int'(ds));
    return (!m_valid || ordy) && src_free(int'(sa)) && src_free(int'(sb)) && !waw;
  endfunction

  function automatic logic [63:0] src_val(int s);
    return (BYP && hit(s)) ? wbd : mm[s];
  endfunction

  function automatic logic [7:0] pend_vec();
    logic [7:0] v;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  // Apply the current inputs for one clock, checking against the reference model.
  task automatic drive();
    bit acc;
    logic [63:0] va, vb;
    @(negedge clk);
    seen_rdy = in_ready;
    acc = iv && model_ready();
    if (!rst) check("in_ready", in_ready, model_ready());
    va = src_val(int'(sa));
    vb = src_val(int'(sb));
    if (rst) begin
      m_valid = 0; m_a = 0; m_b = 0; m_dsel = 0; m_den = 0;
      for (int i = 0; i < 8; i++) m_pend[i] = 0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (acc && de && int'(ds) == i) m_pend[i] = 1;
        else if (hit(i))                m_pend[i] = 0;
      end
      if (acc) begin
        m_valid = 1; m_a = va; m_b = vb; m_dsel = ds; m_den = de;
      end else if (ordy) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("op_a", op_a, m_a);
    check("op_b", op_b, m_b);
    check("out_dst_sel", out_dst_sel, m_dsel);
    check("out_dst_en", out_dst_en, m_den);
    check("pending", dut.pending, pend_vec());
  endtask

  task automatic set_op(input bit v, input bit [2:0] a, input bit [2:0] b,
                        input bit [2:0] d, input bit e);
    iv = v; sa = a; sb = b; ds = d; de = e;
  endtask

  typedef struct {
    bit        rst, iv;
    bit [2:0]  a, b, d;
    bit        de, we;
    bit [2:0]  ws;
    bit        ordy;
    bit        xr, xv;
    bit [63:0] xa, xb;
    bit [7:0]  xp;
  } row_t;

  localparam bit [63:0] DB = 64'hDEAD_BEEF_0000_0001;

  row_t rows [12];
  logic [63:0] hold_a;

  initial begin
    rst = 1; iv = 0; sa = 0; sb = 0; ds = 0; de = 0; we = 0; ws = 0; wbd = 64'hF00D; ordy = 1;
    for (int i = 0; i < 8; i++) mm[i] = 64'h1000 + 64'(i);
    mm[3] = DB;
    mm[5] = 64'h1;

    rows[0]  = '{1, 1, 3, 5, 6, 1, 0, 0, 1,  0, 0, 64'h0,    64'h0,    8'h00};
    rows[1]  = '{0, 1, 3, 5, 6, 1, 0, 0, 1,  1, 1, DB,       64'h1,    8'h40};
    rows[2]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, DB,       64'h1,    8'h40};
    rows[3]  = '{0, 1, 0, 1, 4, 1, 0, 0, 1,  1, 1, 64'h1000, 64'h1001, 8'h50};
    rows[4]  = '{0, 1, 0, 1, 4, 1, 0, 0, 1,  0, 0, 64'h1000, 64'h1001, 8'h50};
    rows[5]  = '{0, 1, 0, 1, 4, 1, 1, 4, 1,  1, 1, 64'h1000, 64'h1001, 8'h50};
    rows[6]  = '{0, 0, 0, 0, 0, 0, 1, 6, 1,  1, 0, 64'h1000, 64'h1001, 8'h10};
    rows[7]  = '{0, 1, 7, 7, 0, 0, 1, 6, 1,  1, 1, 64'h1007, 64'h1007, 8'h10};
    rows[8]  = '{0, 1, 1, 1, 1, 1, 0, 0, 1,  1, 1, 64'h1001, 64'h1001, 8'h12};
    rows[9]  = '{0, 1, 2, 3, 0, 0, 0, 0, 0,  0, 1, 64'h1001, 64'h1001, 8'h12};
    rows[10] = '{0, 1, 2, 3, 0, 0, 0, 0, 1,  1, 1, 64'h1002, DB,       8'h12};
    rows[11] = '{1, 1, 0, 0, 7, 1, 0, 0, 1,  0, 0, 64'h0,    64'h0,    8'h00};

    @(posedge clk); #1;
    for (int k = 0; k < 12; k++) begin
      rst = rows[k].rst; ordy = rows[k].ordy; we = rows[k].we; ws = rows[k].ws;
      set_op(rows[k].iv, rows[k].a, rows[k].b, rows[k].d, rows[k].de);
      drive();
      if (!rows[k].rst) check($sformatf("row%0d_ready", k), seen_rdy, rows[k].xr);
      check($sformatf("row%0d_valid", k), out_valid, rows[k].xv);
      check($sformatf("row%0d_op_a", k), op_a, rows[k].xa);
      check($sformatf("row%0d_op_b", k), op_b, rows[k].xb);
      check($sformatf("row%0d_pending", k), dut.pending, rows[k].xp);
    end
    rst = 0; we = 0;

    // RAW on a pending source, resolved by writeback.
    set_op(1, 0, 1, 2, 1); drive();
    set_op(1, 2, 0, 0, 0);
    drive(); check("raw_stall1", seen_rdy, 0);
    drive(); check("raw_stall2", seen_rdy, 0);
    we = 1; ws = 2; wbd = 64'hCAFE;
    drive();
    if (BYP) begin
      check("raw_bypass_ready", seen_rdy, 1);
      check("raw_bypass_op_a", op_a, 64'hCAFE);
      we = 0; set_op(0, 0, 0, 0, 0); drive();
    end else begin
      check("raw_wb_cycle_ready", seen_rdy, 0);
      we = 0; drive();
      check("raw_late_ready", seen_rdy, 1);
      check("raw_late_op_a", op_a, mm[2]);
    end

    // Backpressure: outputs frozen while execute is not ready.
    set_op(1, 7, 7, 0, 0); ordy = 1; drive();
    hold_a = op_a;
    set_op(1, 3, 4, 0, 0); ordy = 0;
    for (int k = 0; k < 3; k++) begin
      drive();
      check("bp_ready", seen_rdy, 0);
      check("bp_op_a_stable", op_a, hold_a);
      check("bp_valid", out_valid, 1);
    end
    ordy = 1; drive();
    check("bp_release_ready", seen_rdy, 1);
    check("bp_release_op_a", op_a, DB);

    // Fill the scoreboard, then reset with an op in flight.
    for (int k = 0; k < 8; k++) begin
      set_op(1, 3'(k), 3'(k), 3'(k), 1); drive();
    end
    check("pend_full", dut.pending, 8'hFF);
    rst = 1; drive();
    check("rst_valid", out_valid, 0);
    check("rst_pending", dut.pending, 8'h00);
    rst = 0; set_op(0, 0, 0, 0, 0); drive();
    check("rst_no_pulse", out_valid, 0);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rst  = ($urandom_range(0, 199) == 0);
      iv   = ($urandom_range(0, 9) < 7);
      ordy = ($urandom_range(0, 9) < 7);
      sa = 3'($urandom); sb = 3'($urandom); ds = 3'($urandom); de = 1'($urandom);
      we = 1'($urandom); ws = 3'($urandom); wbd = {$urandom, $urandom};
      for (int i = 0; i < 8; i++) mm[i] = {$urandom, $urandom};
      drive();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
